// File: rtl/shared_and_pkg.sv
// Shared definitions for the round-robin AND/clear scheduler.
//   op_e     : per-requester operation select (AND or clear)
//   id_width : width of an encoded requester index for R requesters
package shared_and_pkg;

  typedef enum logic {
    OP_AND   = 1'b0,
    OP_CLEAR = 1'b1
  } op_e;

  function automatic int id_width(input int r);
    return (r <= 1) ? 1 : $clog2(r);
  endfunction

endpackage

// File: rtl/shared_and_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter.
//   req    : request vector, one bit per requester
//   en     : grant enable; no grant is issued while low
//   prio   : index searched first; the search wraps modulo R
//   gnt    : one-hot grant (all zero when nothing is granted)
//   gnt_id : encoded index of the granted requester (0 when no grant)
module rr_arbiter
  import shared_and_pkg::*;
#(
  parameter int R  = 4,
  parameter int IW = id_width(R)
) (
  input  logic [R-1:0]  req,
  input  logic          en,
  input  logic [IW-1:0] prio,
  output logic [R-1:0]  gnt,
  output logic [IW-1:0] gnt_id
);

  logic          found;
  logic [IW-1:0] idx;

  // R is a power of two, so the IW-bit add wraps modulo R on its own.
  always_comb begin
    gnt    = '0;
    gnt_id = '0;
    found  = 1'b0;
    idx    = '0;
    for (int i = 0; i < R; i++) begin
      idx = prio + IW'(i);
      if (en && !found && req[idx]) begin
        gnt[idx] = 1'b1;
        gnt_id   = idx;
        found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/shared_and_scheduler.sv
// Shares one registered N-bit AND/clear datapath among R requesters.
// Handshakes: a requester's operation transfers in the cycle where its
// IN_valid and OUT_ready bits are both high; the result transfers in the
// cycle where OUT_valid and IN_resReady are both high. A grant is only
// issued when the result slot is empty or being drained that cycle, so a
// drain and a new capture can share a cycle (one result per cycle).
//   clk, rst       : clock, synchronous active-high reset
//   IN_valid       : per-requester operation pending
//   OUT_ready      : one-hot combinational grant
//   IN_valA/B      : packed per-requester operands (requester r at [r*N +: N])
//   IN_ctrl        : per-requester op (0 = A & B, 1 = clear)
//   OUT_valid      : result register holds a valid result
//   IN_resReady    : consumer takes the result this cycle
//   OUT_result     : registered result
//   OUT_id         : requester that produced OUT_result
module shared_and_scheduler
  import shared_and_pkg::*;
#(
  parameter int N  = 4,
  parameter int R  = 4,
  parameter int IW = id_width(R)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [R-1:0]    IN_valid,
  output logic [R-1:0]    OUT_ready,
  input  logic [R*N-1:0]  IN_valA,
  input  logic [R*N-1:0]  IN_valB,
  input  logic [R-1:0]    IN_ctrl,
  output logic            OUT_valid,
  input  logic            IN_resReady,
  output logic [N-1:0]    OUT_result,
  output logic [IW-1:0]   OUT_id
);

  logic [IW-1:0] prio;
  logic          accept;
  logic [R-1:0]  gnt;
  logic [IW-1:0] gnt_id;
  logic          grant;
  logic [N-1:0]  op_a;
  logic [N-1:0]  op_b;
  logic [N-1:0]  next_result;

  // Reset is folded into the enable so no grant is visible during reset.
  assign accept = !OUT_valid || IN_resReady;

  rr_arbiter #(.R(R), .IW(IW)) u_arb (
    .req    (IN_valid),
    .en     (accept && !rst),
    .prio   (prio),
    .gnt    (gnt),
    .gnt_id (gnt_id)
  );

  assign OUT_ready = gnt;
  assign grant     = |gnt;

  always_comb begin
    op_a        = IN_valA[int'(gnt_id)*N +: N];
    op_b        = IN_valB[int'(gnt_id)*N +: N];
    next_result = (op_e'(IN_ctrl[gnt_id]) == OP_CLEAR) ? '0 : (op_a & op_b);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      OUT_valid  <= 1'b0;
      OUT_result <= '0;
      OUT_id     <= '0;
      prio       <= '0;
    end else if (grant) begin
      OUT_valid  <= 1'b1;
      OUT_result <= next_result;
      OUT_id     <= gnt_id;
      prio       <= gnt_id + IW'(1);
    end else if (IN_resReady && OUT_valid) begin
      OUT_valid  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_shared_and_scheduler.sv
module tb_shared_and_scheduler;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  IN_valid;
  logic [3:0]  OUT_ready;
  logic [15:0] IN_valA;
  logic [15:0] IN_valB;
  logic [3:0]  IN_ctrl;
  logic        OUT_valid;
  logic        IN_resReady;
  logic [3:0]  OUT_result;
  logic [1:0]  OUT_id;

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  shared_and_scheduler #(.N(4), .R(4)) dut (
    .clk         (clk),
    .rst         (rst),
    .IN_valid    (IN_valid),
    .OUT_ready   (OUT_ready),
    .IN_valA     (IN_valA),
    .IN_valB     (IN_valB),
    .IN_ctrl     (IN_ctrl),
    .OUT_valid   (OUT_valid),
    .IN_resReady (IN_resReady),
    .OUT_result  (OUT_result),
    .OUT_id      (OUT_id)
  );

  // ---------------- scoreboard state ----------------
  int         total = 0;
  int         bad   = 0;
  logic [5:0] exp_q[$];          // {id, result}
  logic [1:0] last_id;
  logic [3:0] last_res;
  logic [3:0] a_op[4];
  logic [3:0] b_op[4];

  // reference model state for the random phase
  logic [1:0] m_prio;
  logic       m_ov;

  typedef struct {
    logic [3:0] v;
    logic [3:0] c;
    logic       rr;
    logic [3:0] rdy;
    logic       ov;
    string      nm;
  } vec_t;
  vec_t tbl[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  function automatic int onehot_idx(input logic [3:0] oh);
    for (int i = 0; i < 4; i++) if (oh[i]) return i;
    return 0;
  endfunction

  // ---------------- driver tasks ----------------
  task automatic do_cycle(input logic [3:0] v, input logic [3:0] c, input logic rr,
                          input logic [3:0] exp_rdy, input logic exp_ov, input string nm);
    logic [5:0] e;
    logic       pushed;
    int         g;
    IN_valid    = v;
    IN_ctrl     = c;
    IN_resReady = rr;
    IN_valA     = {a_op[3], a_op[2], a_op[1], a_op[0]};
    IN_valB     = {b_op[3], b_op[2], b_op[1], b_op[0]};
    @(negedge clk);
    chk({nm, " ready"}, 32'(OUT_ready), 32'(exp_rdy));
    pushed = 1'b0;
    if (exp_rdy != 4'b0000) begin
      g = onehot_idx(exp_rdy);
      exp_q.push_back({2'(g), c[g] ? 4'b0000 : (a_op[g] & b_op[g])});
      pushed = 1'b1;
    end
    @(posedge clk);
    #1;
    chk({nm, " valid"}, 32'(OUT_valid), 32'(exp_ov));
    if (pushed) begin
      e        = exp_q.pop_front();
      last_id  = e[5:4];
      last_res = e[3:0];
    end
    chk({nm, " id"}, 32'(OUT_id), 32'(last_id));
    chk({nm, " result"}, 32'(OUT_result), 32'(last_res));
  endtask

  task automatic do_reset(input string nm);
    rst         = 1'b1;
    IN_valid    = 4'b1111;
    IN_resReady = 1'b1;
    IN_ctrl     = 4'b0000;
    @(negedge clk);
    chk({nm, " ready in reset"}, 32'(OUT_ready), 32'd0);
    @(posedge clk);
    #1;
    chk({nm, " valid"}, 32'(OUT_valid), 32'd0);
    chk({nm, " result"}, 32'(OUT_result), 32'd0);
    chk({nm, " id"}, 32'(OUT_id), 32'd0);
    rst      = 1'b0;
    last_id  = 2'd0;
    last_res = 4'd0;
    m_prio   = 2'd0;
    m_ov     = 1'b0;
    exp_q.delete();
  endtask

  task automatic add(input logic [3:0] v, input logic [3:0] c, input logic rr,
                     input logic [3:0] rdy, input logic ov, input string nm);
    vec_t t;
    t.v = v; t.c = c; t.rr = rr; t.rdy = rdy; t.ov = ov; t.nm = nm;
    tbl.push_back(t);
  endtask

  // model: expected grant for the random phase, then state update
  task automatic model_step(input logic [3:0] v, input logic rr,
                            output logic [3:0] rdy, output logic ov);
    logic [1:0] idx;
    rdy = 4'b0000;
    if (!m_ov || rr) begin
      for (int i = 0; i < 4; i++) begin
        idx = m_prio + 2'(i);
        if (rdy == 4'b0000 && v[idx]) rdy[idx] = 1'b1;
      end
    end
    if (rdy != 4'b0000) begin
      m_ov   = 1'b1;
      m_prio = 2'(onehot_idx(rdy) + 1);
    end else if (rr && m_ov) begin
      m_ov = 1'b0;
    end
    ov = m_ov;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [3:0] v, c, rdy;
    logic       rr, ov;

    rst = 1'b1; IN_valid = '0; IN_ctrl = '0; IN_resReady = 1'b0;
    IN_valA = '0; IN_valB = '0;
    for (int i = 0; i < 4; i++) begin a_op[i] = 4'b1100; b_op[i] = 4'b1010; end
    @(posedge clk);
    do_reset("reset");

    // rotation from prio 0
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, "rot0");
    add(4'b1111, 4'b0000, 1'b1, 4'b0010, 1'b1, "rot1");
    add(4'b1111, 4'b0000, 1'b1, 4'b0100, 1'b1, "rot2");
    add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, "rot3");
    add(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, "rot4");
    // single request to 2 (prio 1 -> 3)
    add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, "single2");
    // clear on 3, then 1 (pointer wraps past 0)
    add(4'b1000, 4'b1000, 1'b1, 4'b1000, 1'b1, "clear3");
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, "wrap1");
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "drain");
    // backpressure
    add(4'b0001, 4'b0000, 1'b1, 4'b0001, 1'b1, "bp_g0");
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, "bp_stall1");
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, "bp_stall2");
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, "bp_stall3");
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, "bp_release");
    // withdrawn request (prio 2 -> 3 after grant 2)
    add(4'b0100, 4'b0000, 1'b1, 4'b0100, 1'b1, "wd_g2");
    add(4'b0010, 4'b0000, 1'b0, 4'b0000, 1'b1, "wd_stall");
    add(4'b0000, 4'b0000, 1'b0, 4'b0000, 1'b1, "wd_drop");
    add(4'b0000, 4'b0000, 1'b1, 4'b0000, 1'b0, "wd_drain");
    add(4'b1111, 4'b0000, 1'b1, 4'b1000, 1'b1, "wd_prio_kept");
    // set up prio=2 with a pending result before mid-stream reset
    add(4'b0010, 4'b0000, 1'b1, 4'b0010, 1'b1, "pre_reset");

    foreach (tbl[i]) do_cycle(tbl[i].v, tbl[i].c, tbl[i].rr, tbl[i].rdy, tbl[i].ov, tbl[i].nm);

    // reset mid-stream, then first grant goes to requester 0
    do_reset("mid_reset");
    do_cycle(4'b1111, 4'b0000, 1'b1, 4'b0001, 1'b1, "post_reset");
    do_reset("reset2");

    // random phase against the reference model
    for (int n = 0; n < 300; n++) begin
      for (int i = 0; i < 4; i++) begin
        a_op[i] = 4'($urandom_range(0, 15));
        b_op[i] = 4'($urandom_range(0, 15));
      end
      v  = 4'($urandom_range(0, 15));
      c  = 4'($urandom_range(0, 15));
      rr = 1'($urandom_range(0, 3) != 0);
      model_step(v, rr, rdy, ov);
      do_cycle(v, c, rr, rdy, ov, "rand");
    end

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/shared_and_scheduler.md
# shared_and_scheduler

Round-robin scheduler that shares one registered N-bit AND/clear datapath among R requesters. Each cycle it grants at most one requester through a valid/ready handshake and captures that requester's result in a single output register, so the shared datapath is used once per cycle. The output stage has its own valid/ready handshake and can be backpressured. The block sits between the requesting processes and the flip-flop datapath.

## Interface
- N, 4, operand and result width
- R, 4, number of requesters (power of two, ≥2)
- clk  in  1  clock, rising edge
- rst  in  1  reset, synchronous, active-high
- IN_valid  in  R  requester r has an operation pending
- OUT_ready  out  R  one-hot grant; bit r high means requester r's operation is accepted this cycle
- IN_valA  in  R×N  operand A per requester
- IN_valB  in  R×N  operand B per requester
- IN_ctrl  in  R  per-requester op: 0 = A & B, 1 = clear (result 0)
- OUT_valid  out  1  result register holds a valid result
- IN_resReady  in  1  consumer accepts the result this cycle
- OUT_result  out  N  registered result
- OUT_id  out  clog2(R)  index of the requester that produced OUT_result

## Operation
- Acceptance condition: accept = !OUT_valid | IN_resReady. The output slot is free or is being drained this cycle.
- Grant is combinational. If accept = 1 and any IN_valid bit is set, OUT_ready is one-hot on the first set bit, searching upward from pointer `prio` and wrapping modulo R. Otherwise OUT_ready = 0.
- An OUT_ready bit is never asserted for a requester whose IN_valid is 0.
- On the clock edge after a grant to requester g:
  - OUT_result ← IN_ctrl[g] ? 0 : (IN_valA[g] & IN_valB[g])
  - OUT_id ← g
  - OUT_valid ← 1
  - prio ← (g+1) mod R
- If there is no grant and IN_resReady & OUT_valid: OUT_valid ← 0. OUT_result and OUT_id hold their values.
- If there is no grant and no drain: all state holds.
- Simultaneous drain and grant in one cycle: the new result replaces the old one and OUT_valid stays 1, giving full throughput of 1 result per cycle.
- Requesters hold IN_valid and their operands until they see their OUT_ready bit. A requester may deassert IN_valid without being granted; the scheduler only ever samples the current cycle's inputs.
- Fairness: a requester that holds IN_valid high is granted within R accepting cycles.
- prio changes only on a grant.

## Timing
- Reset values (the cycle after rst is sampled high): OUT_valid=0, OUT_result=0, OUT_id=0, prio=0. OUT_ready=0 while rst is high.
- Reset in the middle of operation discards any pending result and returns the pointer to 0, with no grant during reset.
- Latency: a grant in cycle t gives OUT_valid=1 with the result in cycle t+1.
- Backpressure:
  - While OUT_valid=1 and IN_resReady=0, OUT_ready stays 0 and OUT_result is stable.
  - When OUT_valid=1, IN_resReady=1 and some IN_valid bit is set, a new grant is issued in that same cycle.
- Wrap-around: after a grant to requester R-1, priority returns to requester 0.
- All outputs except OUT_ready are registered. OUT_ready depends combinationally on IN_valid, IN_resReady, OUT_valid and prio.

## Structure
- Package `shared_and_pkg`:
  - op enum: OP_AND = 0, OP_CLEAR = 1
  - localparam function for the id width, clog2(R)
- Sub-module `rr_arbiter` (parameter R): inputs req[R], en and prio; output one-hot gnt[R] and encoded gnt_id. It is purely combinational.
- The top level holds the prio pointer, the result/valid/id registers and the op mux.

## Test plan
Setup for all cases: N=4, R=4, A=4'b1100, B=4'b1010.
- **Single request, ctrl=0.** Requester 2 valid, IN_resReady=1. Expect OUT_ready=4'b0100 in cycle t; in t+1, OUT_valid=1, OUT_result=4'b1000, OUT_id=2.
- **Round-robin rotation.** All four requesters valid, IN_resReady=1. Expect grants 0,1,2,3,0 on consecutive cycles and OUT_id following one cycle later.
- **Clear op and wrap-around.** Requester 3 with IN_ctrl=1, then requester 1. Expect OUT_result=0 with OUT_id=3, then OUT_result=4'b1000 with OUT_id=1; the pointer wraps past 0 to 1 correctly.
- **Backpressure.** Requester 0 granted, then IN_resReady=0 for 3 cycles with requester 1 valid. Expect OUT_ready=0 and OUT_result/OUT_id (0) held. Raising IN_resReady gives a grant to requester 1 in the same cycle and OUT_id=1 on the next cycle.
- **Reset mid-stream.** Assert rst while OUT_valid=1 and prio=2. Next cycle OUT_valid=0, OUT_result=0, OUT_id=0; with all four requesters valid, the first grant after reset goes to requester 0.
- **Withdrawn request.** Requester 1 drops IN_valid while stalled. Expect requester 1 never granted and prio unchanged.
